// File: rtl/bundle_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, reads LANES-wide bundles from memory and
// queues them in a DEPTH-entry FIFO ahead of decode, with redirect flush and sticky halt.
module bundle_fetch_queue #(
    parameter int unsigned        LANES    = 4,
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [31:0]        RESET_PC = 32'h0,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h00000013)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    output logic [31:0]                 mem_pc_o,
    input  logic [LANES*INST_W-1:0]     mem_bundle_i,
    input  logic [31:0]                 data_start_addr_i,
    input  logic                        stall_i,
    input  logic                        redirect_valid_i,
    input  logic [31:0]                 redirect_pc_i,
    input  logic                        halt_in_i,
    output logic                        bundle_valid_o,
    output logic [31:0]                 bundle_pc_o,
    output logic [LANES*INST_W-1:0]     lane_inst_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o,
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int unsigned BundleW   = LANES * INST_W;
    localparam int unsigned PtrW      = $clog2(DEPTH);
    localparam int unsigned CntW      = $clog2(DEPTH + 1);
    localparam logic [31:0] Step      = 32'(LANES * 4);
    localparam logic [31:0] AlignMask = ~(Step - 32'd1);

    typedef enum logic [1:0] {StFetch, StDrain, StHalted} state_e;

    state_e                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           last_pc_q;
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [31:0]           pc_mem_q     [DEPTH];
    logic [BundleW-1:0]    bundle_mem_q [DEPTH];

    logic full, empty, in_text, flush, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign in_text = (pc_q < data_start_addr_i);
    // Halt outranks redirect, and a halted queue is only ever drained, never flushed.
    assign flush   = redirect_valid_i && !halt_in_i && (state_q != StHalted);
    assign pop     = !empty && !stall_i && !redirect_valid_i;
    assign push    = (state_q == StFetch) && in_text && !redirect_valid_i && (!full || pop);

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            pc_d    = redirect_pc_i & AlignMask;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
                pc_d   = pc_q + Step;
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (pc_d >= data_start_addr_i) state_d = StDrain;
            StDrain:  if (flush && (pc_d < data_start_addr_i)) state_d = StFetch;
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
        if (halt_in_i) begin
            state_d = StHalted;
        end
    end

    // Outputs come from queue storage only; memory data never bypasses to decode.
    always_comb begin
        mem_pc_o       = pc_q;
        bundle_valid_o = !empty;
        bundle_pc_o    = empty ? last_pc_q : pc_mem_q[head_q];
        lane_inst_o    = empty ? {LANES{NOP_INST}} : bundle_mem_q[head_q];
        count_o        = count_q;
        full_o         = full;
        empty_o        = empty;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            last_pc_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (!empty) begin
                last_pc_q <= pc_mem_q[head_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[tail_q]     <= pc_q;
            bundle_mem_q[tail_q] <= mem_bundle_i;
        end
    end

endmodule

// File: tb/tb_bundle_fetch_queue.sv
// Directed bench for bundle_fetch_queue: default 4-lane instance plus a 2-lane/3-deep instance
// that starts near the top of the address space.
module tb_bundle_fetch_queue;
    logic         clk, rst;
    logic [31:0]  mem_pc, dsa, rpc, bpc;
    logic [127:0] mem_bundle, lanes;
    logic         stall, rv, halt, bv, full, empty;
    logic [2:0]   cnt;

    logic [31:0]  mem_pc2, dsa2, rpc2, bpc2;
    logic [63:0]  mem_bundle2, lanes2;
    logic         stall2, rv2, halt2, bv2, full2, empty2;
    logic [1:0]   cnt2;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] NOP4 = {4{32'h00000013}};

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [127:0] bundle4(input logic [31:0] pc);
        return {word_at(pc + 32'd12), word_at(pc + 32'd8), word_at(pc + 32'd4), word_at(pc)};
    endfunction

    function automatic logic [63:0] bundle2(input logic [31:0] pc);
        return {word_at(pc + 32'd4), word_at(pc)};
    endfunction

    assign mem_bundle  = bundle4(mem_pc);
    assign mem_bundle2 = bundle2(mem_pc2);

    bundle_fetch_queue dut (
        .clk_i(clk), .rst_i(rst), .mem_pc_o(mem_pc), .mem_bundle_i(mem_bundle),
        .data_start_addr_i(dsa), .stall_i(stall), .redirect_valid_i(rv), .redirect_pc_i(rpc),
        .halt_in_i(halt), .bundle_valid_o(bv), .bundle_pc_o(bpc), .lane_inst_o(lanes),
        .count_o(cnt), .full_o(full), .empty_o(empty)
    );

    bundle_fetch_queue #(.LANES(2), .DEPTH(3), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk_i(clk), .rst_i(rst), .mem_pc_o(mem_pc2), .mem_bundle_i(mem_bundle2),
        .data_start_addr_i(dsa2), .stall_i(stall2), .redirect_valid_i(rv2),
        .redirect_pc_i(rpc2), .halt_in_i(halt2), .bundle_valid_o(bv2), .bundle_pc_o(bpc2),
        .lane_inst_o(lanes2), .count_o(cnt2), .full_o(full2), .empty_o(empty2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bv !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bv); end
        vectors++; if (bpc !== 32'h0) begin miscompares++; $display("FAIL reset_bundle_pc: got %h expected 0", bpc); end
        vectors++; if (lanes !== NOP4) begin miscompares++; $display("FAIL reset_lanes: got %h expected %h", lanes, NOP4); end
        vectors++; if (cnt !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", cnt); end
        vectors++; if ({full, empty} !== 2'b01) begin miscompares++; $display("FAIL reset_full_empty: got %b expected 01", {full, empty}); end
        vectors++; if (mem_pc !== 32'h0) begin miscompares++; $display("FAIL reset_mem_pc: got %h expected 0", mem_pc); end
    endtask

    task automatic test_fetch_stream();
        dsa = 32'h40; stall = 1'b0;
        do_reset();
        vectors++; if (bv !== 1'b0) begin miscompares++; $display("FAIL no_bypass: got %b expected 0", bv); end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (bv !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, bv); end
            vectors++; if (bpc !== 32'(k * 16)) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, bpc, 32'(k * 16)); end
            vectors++; if (lanes !== bundle4(32'(k * 16))) begin miscompares++; $display("FAIL stream_lanes[%0d]: got %h expected %h", k, lanes, bundle4(32'(k * 16))); end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++; if ({bv, empty} !== 2'b01) begin miscompares++; $display("FAIL drain_empty[%0d]: got %b expected 01", k, {bv, empty}); end
            vectors++; if (lanes !== NOP4) begin miscompares++; $display("FAIL drain_lanes[%0d]: got %h expected %h", k, lanes, NOP4); end
            vectors++; if (bpc !== 32'h30) begin miscompares++; $display("FAIL drain_hold_pc[%0d]: got %h expected 30", k, bpc); end
            vectors++; if (mem_pc !== 32'h40) begin miscompares++; $display("FAIL drain_mem_pc[%0d]: got %h expected 40", k, mem_pc); end
        end
    endtask

    task automatic test_stall_full();
        dsa = 32'h100; stall = 1'b1;
        do_reset();
        repeat (8) tick();
        vectors++; if (cnt !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d expected 4", cnt); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b expected 1", full); end
        vectors++; if (mem_pc !== 32'h40) begin miscompares++; $display("FAIL full_mem_pc: got %h expected 40", mem_pc); end
        vectors++; if (bpc !== 32'h0) begin miscompares++; $display("FAIL full_head: got %h expected 0", bpc); end
        stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++; if (bpc !== 32'(k * 16)) begin miscompares++; $display("FAIL pushpop_head[%0d]: got %h expected %h", k, bpc, 32'(k * 16)); end
            vectors++; if (cnt !== 3'd4) begin miscompares++; $display("FAIL pushpop_count[%0d]: got %0d expected 4", k, cnt); end
            vectors++; if (mem_pc !== 32'(64 + k * 16)) begin miscompares++; $display("FAIL pushpop_mem_pc[%0d]: got %h expected %h", k, mem_pc, 32'(64 + k * 16)); end
        end
    endtask

    task automatic test_redirect();
        dsa = 32'h100; stall = 1'b1;
        do_reset();
        repeat (3) tick();
        stall = 1'b0;
        tick();
        vectors++; if ({cnt, bpc} !== {3'd3, 32'h10}) begin miscompares++; $display("FAIL redir_setup: got %0d/%h expected 3/10", cnt, bpc); end
        stall = 1'b1; rv = 1'b1; rpc = 32'h2C;
        tick();
        rv = 1'b0; stall = 1'b0;
        vectors++; if ({bv, cnt} !== {1'b0, 3'd0}) begin miscompares++; $display("FAIL redir_flush: got %b/%0d expected 0/0", bv, cnt); end
        vectors++; if (mem_pc !== 32'h20) begin miscompares++; $display("FAIL redir_align: got %h expected 20", mem_pc); end
        tick();
        vectors++; if ({bv, bpc} !== {1'b1, 32'h20}) begin miscompares++; $display("FAIL redir_first: got %b/%h expected 1/20", bv, bpc); end
        vectors++; if (lanes !== bundle4(32'h20)) begin miscompares++; $display("FAIL redir_lanes: got %h expected %h", lanes, bundle4(32'h20)); end
        vectors++; if (mem_pc !== 32'h30) begin miscompares++; $display("FAIL redir_next_pc: got %h expected 30", mem_pc); end
    endtask

    task automatic test_halt();
        dsa = 32'h100; stall = 1'b1;
        do_reset();
        repeat (3) tick();
        halt = 1'b1; rv = 1'b1; rpc = 32'h80;
        tick();
        halt = 1'b0; rv = 1'b0; stall = 1'b0;
        vectors++; if ({cnt, bpc} !== {3'd3, 32'h0}) begin miscompares++; $display("FAIL halt_retain: got %0d/%h expected 3/0", cnt, bpc); end
        vectors++; if (mem_pc !== 32'h30) begin miscompares++; $display("FAIL halt_pc: got %h expected 30", mem_pc); end
        for (int k = 1; k <= 2; k++) begin
            tick();
            vectors++; if (bpc !== 32'(k * 16)) begin miscompares++; $display("FAIL halt_drain[%0d]: got %h expected %h", k, bpc, 32'(k * 16)); end
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++; if ({bv, mem_pc} !== {1'b0, 32'h30}) begin miscompares++; $display("FAIL halt_stuck[%0d]: got %b/%h expected 0/30", k, bv, mem_pc); end
        end
    endtask

    task automatic test_wrap();
        dsa2 = 32'hFFFF_FFFF; stall2 = 1'b1;
        do_reset();
        vectors++; if (mem_pc2 !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wrap_reset_pc: got %h expected fffffff8", mem_pc2); end
        tick();
        vectors++; if ({mem_pc2, cnt2} !== {32'h0, 2'd1}) begin miscompares++; $display("FAIL wrap_pc: got %h/%0d expected 0/1", mem_pc2, cnt2); end
        vectors++; if (lanes2 !== bundle2(32'hFFFF_FFF8)) begin miscompares++; $display("FAIL wrap_lanes: got %h expected %h", lanes2, bundle2(32'hFFFF_FFF8)); end
        repeat (3) tick();
        vectors++; if ({full2, cnt2, mem_pc2} !== {1'b1, 2'd3, 32'h10}) begin miscompares++; $display("FAIL wrap_full: got %b/%0d/%h expected 1/3/10", full2, cnt2, mem_pc2); end
        stall2 = 1'b0;
        tick();
        vectors++; if ({cnt2, bpc2, mem_pc2} !== {2'd3, 32'h0, 32'h18}) begin miscompares++; $display("FAIL wrap_continue: got %0d/%h/%h expected 3/0/18", cnt2, bpc2, mem_pc2); end
        vectors++; if (lanes2 !== bundle2(32'h0)) begin miscompares++; $display("FAIL wrap_lanes0: got %h expected %h", lanes2, bundle2(32'h0)); end
    endtask

    task automatic test_async_reset();
        dsa = 32'h100; stall = 1'b1;
        do_reset();
        repeat (5) tick();
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL areset_setup: got %b expected 1", full); end
        #3;
        rst = 1'b1;
        #1;
        vectors++; if ({bv, cnt, full, empty} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL areset_state: got %b/%0d/%b/%b expected 0/0/0/1", bv, cnt, full, empty); end
        vectors++; if ({bpc, mem_pc} !== 64'h0) begin miscompares++; $display("FAIL areset_pcs: got %h/%h expected 0/0", bpc, mem_pc); end
        vectors++; if (lanes !== NOP4) begin miscompares++; $display("FAIL areset_lanes: got %h expected %h", lanes, NOP4); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dsa = 32'h40; stall = 1'b0; rv = 1'b0; rpc = 32'h0; halt = 1'b0;
        dsa2 = 32'hFFFF_FFFF; stall2 = 1'b1; rv2 = 1'b0; rpc2 = 32'h0; halt2 = 1'b0;
        test_reset();
        test_fetch_stream();
        test_stall_full();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
